// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM state
// encoding, default field widths and the per-cycle control output bundle.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W_DEF     = 5;
    // Position of MemRead inside the 3-bit M field {Branch, MemRead, MemWrite}.
    localparam int unsigned M_MEMREAD_IDX = 1;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MD_BUSY = 2'd1,
        S_MD_DONE = 2'd2
    } state_e;

    // Control outputs produced every cycle, grouped so each case is one constant.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_bubble;
        logic md_busy;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_write: 1'b1,
        idex_bubble: 1'b0, exmem_bubble: 1'b0, md_busy: 1'b0
    };
    localparam ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_write: 1'b0,
        idex_bubble: 1'b1, exmem_bubble: 1'b1, md_busy: 1'b0
    };
    // Taken branch/jump: let PC take the target, squash the two younger instructions.
    localparam ctrl_t CTRL_REDIRECT = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_write: 1'b1,
        idex_bubble: 1'b1, exmem_bubble: 1'b0, md_busy: 1'b0
    };
    // Mult/div in EX: hold the front end, keep EX/MEM fed with bubbles.
    localparam ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b0,
        idex_bubble: 1'b0, exmem_bubble: 1'b1, md_busy: 1'b1
    };
    // Load-use: hold PC and IF/ID, let a bubble enter ID/EX.
    localparam ctrl_t CTRL_LOAD_USE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b1,
        idex_bubble: 1'b1, exmem_bubble: 1'b0, md_busy: 1'b0
    };

    // Extract MemRead from an M control field.
    function automatic logic m_memread(input logic [2:0] m_field);
        return m_field[M_MEMREAD_IDX];
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Interface between the pipeline datapath (master) and the stall controller (slave).
interface hazard_stall_ctrl_if
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF,
    parameter int unsigned CNT_W = 16
);

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic             ex_muldiv;
    logic             ex_redirect;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, ex_muldiv, ex_redirect,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
               md_busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, ex_muldiv, ex_redirect,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
               md_busy, stall_cnt
    );

endinterface

// File: rtl/hazard_stall_ctrl_stall_counter.sv
// Saturating up-counter with enable; counts stall cycles for performance monitoring.
module hazard_stall_ctrl_stall_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles, sticking at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: resolves load-use hazards, EX redirects and
// multi-cycle mult/div occupancy of EX by driving stage enables and bubbles.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned REG_W     = REG_W_DEF,
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    hazard_stall_ctrl_if.slave bus
);

    // Start cycle and DONE cycle are part of the occupancy, the rest is counted down.
    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 2);

    state_e           r_state;
    state_e           w_state_next;
    logic [7:0]       r_md_cnt;
    logic [7:0]       w_md_cnt_next;
    logic [REG_W-1:0] w_id_rs;
    logic [REG_W-1:0] w_id_rt;
    logic [REG_W-1:0] w_idex_rt;
    logic             w_load_use;
    ctrl_t            w_ctrl;
    logic [CNT_W-1:0] w_stall_cnt;

    assign w_id_rs   = bus.id_rs;
    assign w_id_rt   = bus.id_rt;
    assign w_idex_rt = bus.idex_rt;

    // A load in EX writing a register that the ID instruction reads ($0 never hazards).
    assign w_load_use = bus.idex_memread && (w_idex_rt != '0) &&
                        ((w_idex_rt == w_id_rs) ||
                         (bus.id_uses_rt && (w_idex_rt == w_id_rt)));

    // Next-state and mult/div countdown.
    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        case (r_state)
            S_RUN: begin
                if (!bus.ex_redirect && bus.ex_muldiv) begin
                    w_md_cnt_next = MD_LOAD;
                    w_state_next  = (MD_LOAD == 8'd0) ? S_MD_DONE : S_MD_BUSY;
                end
            end
            S_MD_BUSY: begin
                w_md_cnt_next = (r_md_cnt == 8'd0) ? 8'd0 : r_md_cnt - 8'd1;
                // Leave once this cycle's decrement brings the count to zero.
                if (r_md_cnt <= 8'd1) begin
                    w_state_next = S_MD_DONE;
                end
            end
            S_MD_DONE: begin
                w_state_next = S_RUN;
            end
            default: begin
                w_state_next  = S_RUN;
                w_md_cnt_next = 8'd0;
            end
        endcase
    end

    // Output decode: same-cycle response to state and hazard inputs.
    always_comb begin
        w_ctrl = CTRL_NORMAL;
        if (!reset_n) begin
            w_ctrl = CTRL_RESET;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.ex_redirect) begin
                        w_ctrl = CTRL_REDIRECT;
                    end else if (bus.ex_muldiv) begin
                        w_ctrl = CTRL_FREEZE;
                    end else if (w_load_use) begin
                        w_ctrl = CTRL_LOAD_USE;
                    end
                end
                S_MD_BUSY: begin
                    w_ctrl = CTRL_FREEZE;
                end
                S_MD_DONE: begin
                    // Redirect and ex_muldiv belong to the finishing op; only load-use acts.
                    if (w_load_use) begin
                        w_ctrl = CTRL_LOAD_USE;
                    end
                end
                default: begin
                    w_ctrl = CTRL_NORMAL;
                end
            endcase
        end
    end

    // State registers; reset aborts any mult/div in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_RUN;
            r_md_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    hazard_stall_ctrl_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (!w_ctrl.pc_write),
        .o_cnt   (w_stall_cnt)
    );

    assign bus.pc_write     = w_ctrl.pc_write;
    assign bus.ifid_write   = w_ctrl.ifid_write;
    assign bus.ifid_flush   = w_ctrl.ifid_flush;
    assign bus.idex_write   = w_ctrl.idex_write;
    assign bus.idex_bubble  = w_ctrl.idex_bubble;
    assign bus.exmem_bubble = w_ctrl.exmem_bubble;
    assign bus.md_busy      = w_ctrl.md_busy;
    assign bus.stall_cnt    = w_stall_cnt;

endmodule
